pe_mac_stream: RTL and testbench

//  Parametrised systolic processing element: next generation of the 8-bit MAC PE.

---
 rtl/pe_pkg.sv | 28 ++
 rtl/pe_sat_add.sv | 42 ++++
 rtl/pe_mac_stream.sv | 145 ++++++++++++++
 tb/tb_pe_mac_stream.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the systolic MAC processing element: FSM encoding,
// default widths and saturation-bound helpers.
package pe_pkg;

    localparam int unsigned PE_DW      = 8;
    localparam int unsigned PE_ACC_W   = 20;
    localparam int unsigned PE_MAX_W   = 128;
    localparam int unsigned PE_STATE_W = 1;

    localparam logic [PE_STATE_W-1:0] PE_IDLE = 1'b0;
    localparam logic [PE_STATE_W-1:0] PE_ACC  = 1'b1;

    // Largest value representable in w bits (signed or unsigned range),
    // returned zero-extended to PE_MAX_W; callers slice off the low w bits.
    function automatic logic [PE_MAX_W-1:0] pe_sat_max(input int unsigned w, input bit sgn);
        logic [PE_MAX_W-1:0] one;
        one = PE_MAX_W'(1);
        return sgn ? ((one << (w - 1)) - one) : ((one << w) - one);
    endfunction

    // Smallest value representable in w bits; callers slice off the low w bits.
    function automatic logic [PE_MAX_W-1:0] pe_sat_min(input int unsigned w, input bit sgn);
        logic [PE_MAX_W-1:0] one;
        one = PE_MAX_W'(1);
        return sgn ? (one << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Accumulator adder: ACC_W-bit add with overflow detection and optional
// clamping to the signed or unsigned range.
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int ACC_W    = PE_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam logic [PE_MAX_W-1:0] MAX_F = pe_sat_max(ACC_W, SIGNED != 0);
    localparam logic [PE_MAX_W-1:0] MIN_F = pe_sat_min(ACC_W, SIGNED != 0);
    localparam logic [ACC_W-1:0]    MAX_V = MAX_F[ACC_W-1:0];
    localparam logic [ACC_W-1:0]    MIN_V = MIN_F[ACC_W-1:0];

    logic [ACC_W:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};

    // Overflow: carry-out when unsigned; same-sign operands giving a result
    // of the other sign when signed. Clamp direction follows operand sign.
    always_comb begin
        o_ovf = 1'b0;
        o_sum = w_raw[ACC_W-1:0];
        if (SIGNED != 0)
            o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
        else
            o_ovf = w_raw[ACC_W];
        if ((SATURATE != 0) && o_ovf) begin
            if ((SIGNED != 0) && i_a[ACC_W-1])
                o_sum = MIN_V;
            else
                o_sum = MAX_V;
        end
    end

endmodule

// File: rtl/pe_mac_stream.sv
// Systolic MAC processing element: forwards A east and B south through one
// register stage, accumulates framed dot products and presents each finished
// sum on a ready/valid result port.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int DW       = PE_DW,
    parameter int ACC_W    = PE_ACC_W,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    input  logic             valid_in,
    input  logic             last_in,
    input  logic             clr,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic             valid_out,
    output logic             last_out,
    output logic [ACC_W-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             sat_flag,
    output logic             overrun
);

    if (ACC_W < 2 * DW) begin : g_bad_acc_w
        $fatal(1, "pe_mac_stream: ACC_W must be at least 2*DW");
    end
    if (ACC_W > PE_MAX_W) begin : g_bad_acc_max
        $fatal(1, "pe_mac_stream: ACC_W exceeds supported maximum");
    end

    logic [PE_STATE_W-1:0] r_state;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_sat;
    logic [ACC_W-1:0]      r_res;
    logic                  r_res_valid;
    logic                  r_overrun;
    logic [DW-1:0]         r_a;
    logic [DW-1:0]         r_b;
    logic                  r_valid;
    logic                  r_last;

    logic [ACC_W-1:0]      w_prod_ext;
    logic                  w_fresh;
    logic [ACC_W-1:0]      w_add_a;
    logic [ACC_W-1:0]      w_sum;
    logic                  w_ovf;
    logic                  w_sat_next;
    logic                  w_load;

    // Full-width product, sign- or zero-extended into the accumulator width.
    if (SIGNED != 0) begin : g_prod_s
        logic signed [2*DW-1:0] w_prod;
        assign w_prod     = $signed(a_in) * $signed(b_in);
        assign w_prod_ext = ACC_W'(w_prod);
    end else begin : g_prod_u
        logic [2*DW-1:0] w_prod;
        assign w_prod     = a_in * b_in;
        assign w_prod_ext = ACC_W'(w_prod);
    end

    // A term starts a fresh sum when idle or when clr discards the partial
    // sum; feeding zero into the adder then makes acc+prod equal prod.
    assign w_fresh    = clr || (r_state == PE_IDLE);
    assign w_add_a    = w_fresh ? '0 : r_acc;
    assign w_sat_next = (w_fresh ? 1'b0 : r_sat) | w_ovf;
    assign w_load     = valid_in && last_in;

    pe_sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .i_a   (w_add_a),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Neighbour forwarding: one unconditional register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_valid <= valid_in;
            r_last  <= last_in;
        end
    end

    // Accumulation FSM; bubbles hold state, clr drops any partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= PE_IDLE;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end else if (valid_in) begin
            r_sat <= w_sat_next;
            if (last_in) begin
                r_state <= PE_IDLE;
            end else begin
                r_state <= PE_ACC;
                r_acc   <= w_sum;
            end
        end else if (clr) begin
            r_state <= PE_IDLE;
            r_sat   <= 1'b0;
        end
    end

    // Result holding register with ready/valid handshake and overrun tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_load) begin
            r_res       <= w_sum;
            r_res_valid <= 1'b1;
            if (r_res_valid && !res_ready)
                r_overrun <= 1'b1;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign valid_out = r_valid;
    assign last_out  = r_last;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign sat_flag  = r_sat;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed self-checking bench for pe_mac_stream: four parameterisations
// (unsigned, signed, 16-bit saturating, 16-bit wrapping) share one stimulus.
module tb_pe_mac_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       valid_in = 1'b0;
    logic       last_in = 1'b0;
    logic       clr = 1'b0;
    logic       res_ready = 1'b0;

    logic [7:0]  ao0, bo0, ao1, bo1, ao2, bo2, ao3, bo3;
    logic        vo0, lo0, vo1, lo1, vo2, lo2, vo3, lo3;
    logic [19:0] res0, res1;
    logic [15:0] res2, res3;
    logic        rv0, rv1, rv2, rv3;
    logic        sf0, sf1, sf2, sf3;
    logic        ov0, ov1, ov2, ov3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_mac_stream #(.DW(8), .ACC_W(20), .SIGNED(0), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .last_in(last_in), .clr(clr), .a_out(ao0), .b_out(bo0), .valid_out(vo0),
        .last_out(lo0), .res(res0), .res_valid(rv0), .res_ready(res_ready),
        .sat_flag(sf0), .overrun(ov0));

    pe_mac_stream #(.DW(8), .ACC_W(20), .SIGNED(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .last_in(last_in), .clr(clr), .a_out(ao1), .b_out(bo1), .valid_out(vo1),
        .last_out(lo1), .res(res1), .res_valid(rv1), .res_ready(res_ready),
        .sat_flag(sf1), .overrun(ov1));

    pe_mac_stream #(.DW(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .last_in(last_in), .clr(clr), .a_out(ao2), .b_out(bo2), .valid_out(vo2),
        .last_out(lo2), .res(res2), .res_valid(rv2), .res_ready(res_ready),
        .sat_flag(sf2), .overrun(ov2));

    pe_mac_stream #(.DW(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u3 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .last_in(last_in), .clr(clr), .a_out(ao3), .b_out(bo3), .valid_out(vo3),
        .last_out(lo3), .res(res3), .res_valid(rv3), .res_ready(res_ready),
        .sat_flag(sf3), .overrun(ov3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic l);
        a_in = a;
        b_in = b;
        valid_in = v;
        last_in = l;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        res_ready = 1'b0;
        tick();
        rst = 1'b1;
        drive(8'd3, 8'd4, 1'b1, 1'b0);
        tick();
        drive(8'd5, 8'd6, 1'b1, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ao0, bo0, vo0, lo0, res0, rv0, sf0, ov0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a_out=%0d b_out=%0d v=%b l=%b res=%0d rv=%b sf=%b ov=%b, expected all 0",
                     ao0, bo0, vo0, lo0, res0, rv0, sf0, ov0);
        end
        tick();
        rst = 1'b1;
        drive(8'd2, 8'd2, 1'b1, 1'b1);
        tick();
        checks++;
        if (res0 !== 20'd4 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: got res=%0d rv=%b, expected res=4 rv=1", res0, rv0);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        res_ready = 1'b1;
        tick();
        checks++;
        if (rv0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_consume: got rv=%b, expected 0", rv0);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] va [4] = '{8'd1, 8'd9, 8'd3, 8'd5};
        logic [7:0] vb [4] = '{8'd2, 8'd8, 8'd4, 8'd6};
        logic       vv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       vl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vv[i], vl[i]);
            tick();
            checks++;
            if (ao0 !== va[i] || bo0 !== vb[i] || vo0 !== vv[i] || lo0 !== vl[i]) begin
                errors++;
                $display("FAIL passthru[%0d]: got a=%0d b=%0d v=%b l=%b, expected a=%0d b=%0d v=%b l=%b",
                         i, ao0, bo0, vo0, lo0, va[i], vb[i], vv[i], vl[i]);
            end
        end
        checks++;
        if (res0 !== 20'd44 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL dot_bubbles: got res=%0d rv=%b, expected res=44 rv=1", res0, rv0);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_signed();
        res_ready = 1'b1;
        drive(8'hFD, 8'd7, 1'b1, 1'b0);
        tick();
        drive(8'd2, 8'hFB, 1'b1, 1'b1);
        tick();
        checks++;
        if (res1 !== 20'hFFFE1 || rv1 !== 1'b1) begin
            errors++;
            $display("FAIL signed_dot: got res=%h rv=%b, expected res=fffe1 rv=1", res1, rv1);
        end
        checks++;
        if (res0 !== 20'd2273) begin
            errors++;
            $display("FAIL unsigned_same_bits: got res=%0d, expected 2273", res0);
        end
        drive(8'h80, 8'h80, 1'b1, 1'b1);
        tick();
        checks++;
        if (res1 !== 20'd16384 || sf1 !== 1'b0) begin
            errors++;
            $display("FAIL signed_minmin: got res=%0d sf=%b, expected res=16384 sf=0", res1, sf1);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        drive(8'd255, 8'd255, 1'b1, 1'b0);
        tick();
        checks++;
        if (sf2 !== 1'b0 || sf3 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first_term: got sf_sat=%b sf_wrap=%b, expected 0 0", sf2, sf3);
        end
        tick();
        checks++;
        if (sf2 !== 1'b1 || sf3 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_mid_sum: got sf_sat=%b sf_wrap=%b, expected 1 1", sf2, sf3);
        end
        tick();
        drive(8'd255, 8'd255, 1'b1, 1'b1);
        tick();
        checks++;
        if (res2 !== 16'hFFFF || sf2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_saturate: got res=%h sf=%b, expected res=ffff sf=1", res2, sf2);
        end
        checks++;
        if (res3 !== 16'(32'd260100 % 32'd65536) || sf3 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap: got res=%h sf=%b, expected res=f804 sf=1", res3, sf3);
        end
        checks++;
        if (res0 !== 20'd260100 || sf0 !== 1'b0) begin
            errors++;
            $display("FAIL wide_no_ovf: got res=%0d sf=%b, expected res=260100 sf=0", res0, sf0);
        end
        drive(8'd1, 8'd1, 1'b1, 1'b0);
        tick();
        checks++;
        if (sf2 !== 1'b0 || sf3 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag_clear: got sf_sat=%b sf_wrap=%b, expected 0 0", sf2, sf3);
        end
        drive(8'd1, 8'd1, 1'b1, 1'b1);
        tick();
        checks++;
        if (res2 !== 16'd2 || res3 !== 16'd2) begin
            errors++;
            $display("FAIL ovf_next_sum: got res_sat=%0d res_wrap=%0d, expected 2 2", res2, res3);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        res_ready = 1'b0;
        drive(8'd2, 8'd5, 1'b1, 1'b1);
        tick();
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (res0 !== 20'd10 || rv0 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got res=%0d rv=%b ov=%b, expected res=10 rv=1 ov=0", res0, rv0, ov0);
        end
        drive(8'd4, 8'd5, 1'b1, 1'b1);
        tick();
        checks++;
        if (res0 !== 20'd20 || rv0 !== 1'b1 || ov0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun: got res=%0d rv=%b ov=%b, expected res=20 rv=1 ov=1", res0, rv0, ov0);
        end
        apply_reset();
        res_ready = 1'b0;
        drive(8'd2, 8'd5, 1'b1, 1'b1);
        tick();
        res_ready = 1'b1;
        drive(8'd4, 8'd5, 1'b1, 1'b1);
        tick();
        checks++;
        if (res0 !== 20'd20 || rv0 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_load_accept: got res=%0d rv=%b ov=%b, expected res=20 rv=1 ov=0", res0, rv0, ov0);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (rv0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got rv=%b, expected 0", rv0);
        end
    endtask

    task automatic test_clr();
        res_ready = 1'b0;
        drive(8'd5, 8'd10, 1'b1, 1'b0);
        tick();
        clr = 1'b1;
        drive(8'd2, 8'd3, 1'b1, 1'b1);
        tick();
        checks++;
        if (res0 !== 20'd6 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_valid: got res=%0d rv=%b, expected res=6 rv=1", res0, rv0);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        checks++;
        if (res0 !== 20'd6 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_keeps_result: got res=%0d rv=%b, expected res=6 rv=1", res0, rv0);
        end
        res_ready = 1'b1;
        drive(8'd7, 8'd7, 1'b1, 1'b0);
        tick();
        clr = 1'b1;
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        drive(8'd1, 8'd1, 1'b1, 1'b1);
        tick();
        checks++;
        if (res0 !== 20'd1 || rv0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_alone: got res=%0d rv=%b, expected res=1 rv=1", res0, rv0);
        end
        drive(8'd0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_bubbles();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
